// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit for the ysyx_25020047 multi-cycle core: owns the PC,
// fetches one word per instruction and hands it to the decoder.
module ysyx_25020047_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] snpc,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fetch_err,
  output logic [31:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_EXEC = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] inst_cnt_r, inst_cnt_s;
  logic        fetch_err_r, fetch_err_s;
  logic        npc_misaligned_s;

  assign npc_misaligned_s = (npc[1:0] != 2'b00);

  // Next-state and datapath update decode.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    inst_s      = inst_r;
    inst_cnt_s  = inst_cnt_r;
    fetch_err_s = fetch_err_r;
    case (state_r)
      S_REQ: begin
        // A response arriving here is stale and intentionally dropped.
        if (mem_req_ready) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          inst_s  = mem_resp_data;
          state_s = S_HOLD;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          inst_cnt_s = inst_cnt_r + 32'd1;
          state_s    = S_EXEC;
        end else begin
          state_s = S_HOLD;
        end
      end
      S_EXEC: begin
        if (npc_valid) begin
          if (npc_misaligned_s) begin
            fetch_err_s = 1'b1;
            state_s     = S_ERR;
          end else begin
            pc_s    = npc;
            state_s = S_REQ;
          end
        end else begin
          state_s = S_EXEC;
        end
      end
      S_ERR: begin
        state_s = S_ERR;
      end
      default: begin
        // Corrupted state encoding: park safely and raise the error flag.
        fetch_err_s = 1'b1;
        state_s     = S_ERR;
      end
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      inst_r      <= 32'h0000_0000;
      inst_cnt_r  <= 32'h0000_0000;
      fetch_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      inst_r      <= inst_s;
      inst_cnt_r  <= inst_cnt_s;
      fetch_err_r <= fetch_err_s;
    end
  end

  // Request is held off while reset is asserted, even though state already reads REQ.
  assign mem_req_valid = (state_r == S_REQ) && !rst;
  assign inst_valid    = (state_r == S_HOLD);
  assign mem_addr      = pc_r;
  assign pc            = pc_r;
  assign snpc          = pc_r + 32'd4;
  assign inst          = inst_r;
  assign inst_cnt      = inst_cnt_r;
  assign fetch_err     = fetch_err_r;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Self-checking bench for ysyx_25020047_ifu: the bench plays memory, decoder and
// execute stage, and tracks the expected PC/instruction/count per transaction.
module tb_ysyx_25020047_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fetch_err;
  logic [31:0] inst_cnt;

  always #5 clk = ~clk;

  ysyx_25020047_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .npc_valid      (npc_valid),
    .npc            (npc),
    .fetch_err      (fetch_err),
    .inst_cnt       (inst_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the fetch unit must be holding at any moment.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rnd(input bit en);
    return en && ($urandom_range(0, 1) == 1);
  endfunction

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic nv, input logic [31:0] nn);
    mem_req_ready  = rr;
    mem_resp_valid = rv;
    mem_resp_data  = rd;
    inst_ready     = ir;
    npc_valid      = nv;
    npc            = nn;
  endtask

  task automatic check_common(input string tag);
    check({tag, "_pc"},   pc,       m_pc);
    check({tag, "_snpc"}, snpc,     m_pc + 32'd4);
    check({tag, "_inst"}, inst,     m_inst);
    check({tag, "_cnt"},  inst_cnt, m_cnt);
    check({tag, "_err"},  32'(fetch_err), 32'(m_err));
  endtask

  // One full instruction: request, response, decoder handoff, next PC.
  task automatic do_instr(input logic [31:0] word, input logic [31:0] next,
                          input int rq, input int rs, input int dc, input int nd,
                          input bit noise);
    for (int i = 0; i <= rq; i++) begin
      @(negedge clk);
      check_common("req");
      check("req_valid", 32'(mem_req_valid), 32'd1);
      check("req_addr", mem_addr, m_pc);
      check("req_ivalid", 32'(inst_valid), 32'd0);
      drive(i == rq, rnd(noise), $urandom, rnd(noise), rnd(noise), $urandom);
    end
    for (int i = 0; i <= rs; i++) begin
      @(negedge clk);
      check_common("wait");
      check("wait_req_valid", 32'(mem_req_valid), 32'd0);
      check("wait_ivalid", 32'(inst_valid), 32'd0);
      drive(rnd(noise), i == rs, word, rnd(noise), rnd(noise), $urandom);
    end
    m_inst = word;
    for (int i = 0; i <= dc; i++) begin
      @(negedge clk);
      check_common("hold");
      check("hold_ivalid", 32'(inst_valid), 32'd1);
      check("hold_req_valid", 32'(mem_req_valid), 32'd0);
      drive(rnd(noise), rnd(noise), $urandom, i == dc, rnd(noise), $urandom);
    end
    m_cnt = m_cnt + 32'd1;
    for (int i = 0; i <= nd; i++) begin
      @(negedge clk);
      check_common("exec");
      check("exec_ivalid", 32'(inst_valid), 32'd0);
      check("exec_req_valid", 32'(mem_req_valid), 32'd0);
      drive(rnd(noise), rnd(noise), $urandom, rnd(noise), i == nd, next);
    end
    if (next[1:0] == 2'b00) m_pc = next;
    else m_err = 1'b1;
  endtask

  task automatic err_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_common("err");
      check("err_req_valid", 32'(mem_req_valid), 32'd0);
      check("err_ivalid", 32'(inst_valid), 32'd0);
      drive(rnd(1'b1), rnd(1'b1), $urandom, rnd(1'b1), rnd(1'b1), 32'h8000_0010);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_inst = 32'h0000_0000;
    m_cnt  = 32'h0000_0000;
    m_err  = 1'b0;
  endtask

  initial begin
    logic [31:0] tmp;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_ivalid", 32'(inst_valid), 32'd0);
    check_common("rst");
    rst = 1'b0;
    #1 check("rel_req_valid", 32'(mem_req_valid), 32'd1);

    // Zero-wait sequential fetches of the addi-nop word.
    for (int k = 0; k < 3; k++) do_instr(32'h0000_0013, m_pc + 32'd4, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    check("seq_cnt3", inst_cnt, 32'd3);
    check("seq_pc", pc, 32'h8000_000C);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Slow memory, then slow decoder.
    do_instr($urandom, m_pc + 32'd4, 3, 5, 0, 0, 1'b0);
    do_instr($urandom, m_pc + 32'd4, 0, 0, 4, 0, 1'b1);

    // PC at top of address space: snpc wraps to zero.
    do_instr($urandom, 32'hFFFF_FFFC, 0, 0, 0, 2, 1'b1);
    @(negedge clk);
    check("wrap_snpc", snpc, 32'h0000_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_instr($urandom, RESET_PC, 1, 1, 1, 1, 1'b1);

    // Random traffic with random stalls and ignored noise.
    for (int k = 0; k < 40; k++) begin
      tmp = $urandom;
      tmp[1:0] = 2'b00;
      do_instr($urandom, tmp, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    // Reset during WAIT, then a stale response right after release.
    @(negedge clk);
    check("rw_req_valid", 32'(mem_req_valid), 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("rw_wait_req_valid", 32'(mem_req_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    model_reset();
    #1;
    check("rw_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check_common("rw_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("rw_stale_ivalid", 32'(inst_valid), 32'd0);
    check("rw_stale_req_valid", 32'(mem_req_valid), 32'd1);
    check_common("rw_stale");
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_instr($urandom, m_pc + 32'd4, 0, 0, 0, 0, 1'b1);
    do_instr($urandom, m_pc + 32'd4, 0, 1, 0, 1, 1'b1);
    @(negedge clk);
    check("rw_cnt2", inst_cnt, 32'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Misaligned next PC: terminal error until reset.
    do_instr($urandom, 32'h8000_0102, 0, 0, 0, 0, 1'b1);
    err_cycles(6);
    @(negedge clk);
    check("err_flag", 32'(fetch_err), 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();
    #1;
    check("err_rst_flag", 32'(fetch_err), 32'd0);
    check("err_rst_pc", pc, 32'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    do_instr($urandom, m_pc + 32'd4, 0, 0, 0, 0, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_25020047_ifu.md
# ysyx_25020047_ifu

Instruction fetch unit for the ysyx_25020047 multi-cycle core: owns the architectural PC, issues one word read per instruction to instruction memory and hands the fetched word to the decoder over a valid/ready handshake. It sits upstream of the decoder, which consumes `inst` and `pc`. It waits for the execute/writeback stage to return the next PC before it starts the following fetch. It also flags misaligned next-PC values and counts retired fetches.

## Interface
- `RESET_PC`, 32'h8000_0000, PC loaded on reset; must be word-aligned
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `mem_req_valid`  output  1  read request to instruction memory
- `mem_req_ready`  input  1  memory accepts request this cycle
- `mem_addr`  output  32  request address (= `pc`)
- `mem_resp_valid`  input  1  read data valid
- `mem_resp_data`  input  32  read data
- `inst_valid`  output  1  `inst`/`pc` valid toward decoder
- `inst_ready`  input  1  decoder accepts instruction
- `inst`  output  32  fetched instruction word (registered)
- `pc`  output  32  address of current instruction
- `snpc`  output  32  static next PC, `pc + 4`
- `npc_valid`  input  1  execute stage presents next PC
- `npc`  input  32  next PC (dnpc) from execute stage
- `fetch_err`  output  1  sticky: misaligned `npc` received
- `inst_cnt`  output  32  number of completed decoder handoffs

## Operation
- States: REQ, WAIT, HOLD, EXEC, ERR (one-hot or binary, implementer's choice).
- REQ: `mem_req_valid`=1, `mem_addr`=`pc`. On `mem_req_ready`=1 -> WAIT; else stay, address stable.
- WAIT: on `mem_resp_valid`=1, `inst` <= `mem_resp_data`, -> HOLD. `mem_resp_valid` in any other state is ignored (stale responses after reset discarded).
- HOLD: `inst_valid`=1; `inst`, `pc` stable. On `inst_ready`=1 -> EXEC, `inst_cnt` += 1.
- EXEC: waits for `npc_valid`. If `npc[1:0]`==0: `pc` <= `npc`, -> REQ. Else: `pc` unchanged, `fetch_err` <= 1, -> ERR.
- ERR: terminal until reset; no requests, `inst_valid`=0.
- `npc_valid` outside EXEC is ignored; `pc` never changes except in EXEC or reset.
- `snpc` = `pc + 4` combinational, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- `inst_cnt` wraps 0xFFFF_FFFF -> 0.
- `mem_req_valid` and `inst_valid` are pure decodes of state; no combinational path from any input to any output except `snpc` from `pc`.

## Timing
- Reset values (asserted asynchronously): state=REQ, `pc`=`RESET_PC`, `inst`=0, `inst_cnt`=0, `fetch_err`=0, `inst_valid`=0. `mem_req_valid` forced 0 while `rst`=1; 1 in first cycle after deassertion.
- Request accepted cycle N -> WAIT at N+1. Earliest response accepted at N+1 -> HOLD, `inst` valid at N+2.
- Handshake at cycle K -> EXEC at K+1, `inst_cnt` visible incremented at K+1.
- `npc_valid` at cycle J -> new `pc` and REQ at J+1.
- Minimum 4 cycles per instruction with zero-wait memory and decoder.
- Reset mid-WAIT or mid-HOLD: fetch abandoned, next request at `RESET_PC`; late response from aborted request ignored because state is REQ.
- Simultaneous `mem_req_ready` and `mem_resp_valid` in REQ: only the request handshake counts.

## Test plan
- Reset release, memory always ready, returns 0x00000013 one cycle after accept, decoder always ready, `npc`=`snpc` -> addresses 0x80000000, 0x80000004, 0x80000008 issued 4 cycles apart; `inst_cnt` 1,2,3.
- `mem_req_ready` low 3 cycles, response delayed 5 cycles -> `mem_addr` stable throughout; single HOLD with correct `inst`.
- `inst_ready` low 4 cycles in HOLD -> `inst`/`pc` stable, `inst_cnt` increments exactly once.
- `npc`=0x80000102 in EXEC -> `fetch_err`=1 next cycle, no further `mem_req_valid`, `pc` stays; reset clears.
- `pc` driven to 0xFFFFFFFC via `npc` -> `snpc`=0x00000000; `npc_valid` pulsed during WAIT/HOLD -> `pc` unchanged.
- Assert `rst` during WAIT, then return stale `mem_resp_valid` right after release -> ignored; fetch restarts at 0x80000000, `inst_cnt`=0.
